// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types for the async FIFO read-side output stage.
// Provides the output-buffer occupancy encoding and buffer depth.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_obuf.sv
// fifo_rd_obuf: 2-entry FIFO-ordered output buffer.
// Ports: rclk/rrst clock and sync reset; push/wdata write the tail;
//        pop advances the head; rdata is the head; occ the fill level.
module fifo_rd_obuf
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             push,
    input  logic             pop,
    input  logic [DSIZE-1:0] wdata,
    output logic [DSIZE-1:0] rdata,
    output occ_t             occ
);

    logic [DSIZE-1:0] mem [OBUF_DEPTH];
    logic             wptr;
    logic             rptr;
    logic             wr_en;
    logic             rd_en;
    occ_t             occ_q;
    occ_t             occ_d;

    // A push into a full buffer is dropped; the credit logic
    // upstream keeps it from ever happening.
    assign wr_en = push & (occ_q != OCC_TWO);
    assign rd_en = pop & (occ_q != OCC_EMPTY);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    always_comb begin
        occ_d = occ_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (wr_en) begin
                    occ_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                unique case ({wr_en, rd_en})
                    2'b10:   occ_d = OCC_TWO;
                    2'b01:   occ_d = OCC_EMPTY;
                    default: occ_d = OCC_ONE;
                endcase
            end
            OCC_TWO: begin
                if (rd_en) begin
                    occ_d = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (rd_en) begin
                rptr <= ~rptr;
            end
        end
    end

    assign rdata = mem[rptr];
    assign occ   = occ_q;

endmodule

// File: rtl/fifo_rd_out_stage.sv
// fifo_rd_out_stage: async FIFO read-side output stage (rclk domain).
// Ports: rclk/rrst clock and sync reset; rempty/rinc pointer handshake;
//        mem_rdata registered memory data; m_data/m_valid/m_ready
//        output stream; rd_count words accepted downstream.
module fifo_rd_out_stage
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    output logic             rinc,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNTW-1:0]  rd_count
);

    logic       inflight;
    logic       pop;
    logic [2:0] credit;
    occ_t       occ;

    assign m_valid = (occ != OCC_EMPTY);
    assign pop     = m_valid & m_ready;

    // Slots committed after this cycle; pop never exceeds occ,
    // so the subtraction cannot underflow.
    assign credit = 3'(occ) + 3'(inflight) - 3'(pop);

    // Issue a read only when a buffer slot is certain to be free
    // when the registered data arrives next cycle.
    assign rinc = ~rempty & ~rrst & (credit < 3'd2);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rinc;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 1'b1;
        end
    end

    fifo_rd_obuf #(
        .DSIZE (DSIZE)
    ) u_obuf (
        .rclk  (rclk),
        .rrst  (rrst),
        .push  (inflight),
        .pop   (pop),
        .wdata (mem_rdata),
        .rdata (m_data),
        .occ   (occ)
    );

endmodule

// File: tb/tb_fifo_rd_out_stage.sv
// tb_fifo_rd_out_stage: directed bench for the FIFO read output stage.
// Models the FIFO memory/pointer side and checks the output stream.
module tb_fifo_rd_out_stage;
    import fifo_rd_pkg::*;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        rempty;
    logic        rinc;
    logic        rinc4;
    logic [7:0]  mem_rdata;
    logic [7:0]  m_data;
    logic [7:0]  m_data4;
    logic        m_valid;
    logic        m_valid4;
    logic        m_ready;
    logic [15:0] rd_count;
    logic [3:0]  rd_count4;

    logic [7:0]  fmem [64];
    logic [5:0]  rptr;
    logic [5:0]  wptr;
    logic [7:0]  got [$];
    int          checks = 0;
    int          errors = 0;

    always #5 rclk = ~rclk;

    assign rempty = (rptr == wptr);

    fifo_rd_out_stage #(.DSIZE(8), .CNTW(16)) u_dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rinc      (rinc),
        .mem_rdata (mem_rdata),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .rd_count  (rd_count)
    );

    fifo_rd_out_stage #(.DSIZE(8), .CNTW(4)) u_dut4 (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rinc      (rinc4),
        .mem_rdata (mem_rdata),
        .m_data    (m_data4),
        .m_valid   (m_valid4),
        .m_ready   (m_ready),
        .rd_count  (rd_count4)
    );

    // Registered FIFO memory: data of the issued address is valid
    // the cycle after rinc; otherwise a junk value is presented.
    always @(posedge rclk) begin
        if (rrst) begin
            rptr      <= '0;
            mem_rdata <= '0;
        end else if (rinc) begin
            mem_rdata <= fmem[rptr];
            rptr      <= rptr + 6'd1;
        end else begin
            mem_rdata <= 8'hEE;
        end
    end

    always begin
        @(negedge rclk);
        #2;
        if (!rrst) begin
            if (m_valid && m_ready) got.push_back(m_data);
            checks++;
            if (u_dut.inflight && u_dut.occ == OCC_TWO) begin
                errors++;
                $display("FAIL push_in_two got=occ TWO with push exp=no push");
            end
        end
    end

    task automatic apply_reset;
        @(negedge rclk);
        rrst    = 1'b1;
        wptr    = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge rclk);
        rrst = 1'b0;
        got.delete();
    endtask

    task automatic load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            fmem[wptr + 6'(i)] = base + 8'(i);
        end
        wptr = wptr + 6'(n);
    endtask

    task automatic test_reset;
        @(negedge rclk);
        rrst    = 1'b1;
        m_ready = 1'b0;
        wptr    = '0;
        got.delete();
        load(1, 8'h5A);
        repeat (2) @(negedge rclk);
        #1;
        checks++;
        if (rinc !== 1'b0) begin
            errors++;
            $display("FAIL rst_rinc got=%0b exp=0", rinc);
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got=%0b exp=0", m_valid);
        end
        checks++;
        if (rd_count !== 16'd0 || rd_count4 !== 4'd0) begin
            errors++;
            $display("FAIL rst_count got=%0d/%0d exp=0", rd_count, rd_count4);
        end
        rrst = 1'b0;
        #1;
        checks++;
        if (rinc !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_rinc got=%0b exp=1", rinc);
        end
        m_ready = 1'b1;
        repeat (4) @(negedge rclk);
        #1;
        checks++;
        if (got.size() != 1 || got[0] !== 8'h5A) begin
            errors++;
            $display("FAIL rst_word got=%0d words exp=1 word 5a", got.size());
        end
    endtask

    task automatic test_single;
        apply_reset();
        load(1, 8'hA5);
        m_ready = 1'b1;
        #1;
        checks++;
        if (rinc !== 1'b1) begin
            errors++;
            $display("FAIL single_rinc_t got=%0b exp=1", rinc);
        end
        @(negedge rclk);
        #1;
        checks++;
        if (rinc !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_t1 got=rinc %0b valid %0b exp=0 0",
                     rinc, m_valid);
        end
        @(negedge rclk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_t2 got=valid %0b data %h exp=1 a5",
                     m_valid, m_data);
        end
        @(negedge rclk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || rd_count !== 16'd1) begin
            errors++;
            $display("FAIL single_t3 got=valid %0b count %0d exp=0 1",
                     m_valid, rd_count);
        end
    endtask

    task automatic test_burst;
        logic       exp_v;
        logic [7:0] exp_d;
        apply_reset();
        load(8, 8'h01);
        m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_v = (c >= 2 && c < 10);
            exp_d = 8'(c - 1);
            checks++;
            if (rinc !== (c < 8)) begin
                errors++;
                $display("FAIL burst_rinc c=%0d got=%0b exp=%0b",
                         c, rinc, (c < 8));
            end
            checks++;
            if (m_valid !== exp_v) begin
                errors++;
                $display("FAIL burst_valid c=%0d got=%0b exp=%0b",
                         c, m_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (m_data !== exp_d) begin
                    errors++;
                    $display("FAIL burst_data c=%0d got=%h exp=%h",
                             c, m_data, exp_d);
                end
            end
            @(negedge rclk);
        end
        #1;
        checks++;
        if (rd_count !== 16'd8) begin
            errors++;
            $display("FAIL burst_count got=%0d exp=8", rd_count);
        end
    endtask

    task automatic test_backpressure;
        int pulses;
        pulses = 0;
        apply_reset();
        load(5, 8'h11);
        m_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (rinc === 1'b1) pulses++;
            @(negedge rclk);
        end
        #1;
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL bp_pulses got=%0d exp=2", pulses);
        end
        checks++;
        if (u_dut.occ !== OCC_TWO) begin
            errors++;
            $display("FAIL bp_occ got=%0d exp=2", u_dut.occ);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h11) begin
            errors++;
            $display("FAIL bp_head got=valid %0b data %h exp=1 11",
                     m_valid, m_data);
        end
        @(negedge rclk);
        #1;
        checks++;
        if (m_data !== 8'h11 || rinc !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got=data %h rinc %0b exp=11 0",
                     m_data, rinc);
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (rinc !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume got=%0b exp=1", rinc);
        end
        repeat (12) @(negedge rclk);
        #1;
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL bp_size got=%0d exp=5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'h11 + 8'(i)) begin
                errors++;
                $display("FAIL bp_order i=%0d got=%h exp=%h",
                         i, got[i], 8'h11 + 8'(i));
            end
        end
        checks++;
        if (rd_count !== 16'd5) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=5", rd_count);
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        load(8, 8'h40);
        m_ready = 1'b0;
        repeat (4) @(negedge rclk);
        #1;
        checks++;
        if (u_dut.occ !== OCC_TWO) begin
            errors++;
            $display("FAIL mid_pre_two got=%0d exp=2", u_dut.occ);
        end
        m_ready = 1'b1;
        @(negedge rclk);
        #1;
        checks++;
        if (u_dut.occ !== OCC_ONE || u_dut.inflight !== 1'b1 ||
            rd_count !== 16'd1) begin
            errors++;
            $display("FAIL mid_pre got=occ %0d infl %0b cnt %0d exp=1 1 1",
                     u_dut.occ, u_dut.inflight, rd_count);
        end
        rrst    = 1'b1;
        m_ready = 1'b0;
        wptr    = '0;
        #1;
        checks++;
        if (rinc !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_rinc got=%0b exp=0", rinc);
        end
        @(negedge rclk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_valid got=%0b exp=0", m_valid);
        end
        checks++;
        if (rd_count !== 16'd0 || rd_count4 !== 4'd0) begin
            errors++;
            $display("FAIL mid_count got=%0d/%0d exp=0",
                     rd_count, rd_count4);
        end
        rrst = 1'b0;
        @(negedge rclk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || u_dut.occ !== OCC_EMPTY) begin
            errors++;
            $display("FAIL mid_no_push got=valid %0b occ %0d exp=0 0",
                     m_valid, u_dut.occ);
        end
    endtask

    task automatic test_wrap;
        apply_reset();
        load(17, 8'h30);
        m_ready = 1'b1;
        repeat (24) @(negedge rclk);
        #1;
        checks++;
        if (rd_count4 !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count4 got=%0d exp=1", rd_count4);
        end
        checks++;
        if (rd_count !== 16'd17) begin
            errors++;
            $display("FAIL wrap_count16 got=%0d exp=17", rd_count);
        end
        checks++;
        if (got.size() != 17) begin
            errors++;
            $display("FAIL wrap_size got=%0d exp=17", got.size());
        end
        for (int i = 0; i < 17 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'h30 + 8'(i)) begin
                errors++;
                $display("FAIL wrap_seq i=%0d got=%h exp=%h",
                         i, got[i], 8'h30 + 8'(i));
            end
        end
    endtask

    initial begin
        rrst    = 1'b1;
        m_ready = 1'b0;
        wptr    = '0;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
